// File: rtl/m68k_bus_initiator_if.sv
// Bundles the request-side handshake and the 68000-style bus pins of the
// bus initiator. The "master" modport is the initiator itself; the "slave"
// modport is everything around it (requester plus chipset).
//
// Handshake: the requester raises req with the address, direction, byte
// enables and write data stable. The request is taken on the first clk edge
// where req=1 and busy=0, and busy rises on that edge. While busy=1, req is
// ignored and nothing is queued. The transfer ends with a one-clk done pulse,
// with busy already low. err is valid together with done (1 = DTACK timeout).
// rdata holds the data of the last read that completed without error.
interface m68k_bus_initiator_if;
  logic        req;
  logic [22:0] req_addr;
  logic        req_we;
  logic        req_uds;
  logic        req_lds;
  logic [15:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic [22:0] cpu_address;
  logic [15:0] cpu_data_out;
  logic [15:0] cpu_data_in;
  logic        _cpu_as;
  logic        _cpu_uds;
  logic        _cpu_lds;
  logic        cpu_r_w;
  logic        _cpu_dtack;

  modport master (
    input  req, req_addr, req_we, req_uds, req_lds, req_wdata,
    input  cpu_data_in, _cpu_dtack,
    output busy, done, err, rdata,
    output cpu_address, cpu_data_out, _cpu_as, _cpu_uds, _cpu_lds, cpu_r_w
  );

  modport slave (
    output req, req_addr, req_we, req_uds, req_lds, req_wdata,
    output cpu_data_in, _cpu_dtack,
    input  busy, done, err, rdata,
    input  cpu_address, cpu_data_out, _cpu_as, _cpu_uds, _cpu_lds, cpu_r_w
  );
endinterface

// File: rtl/m68k_bus_initiator.sv
// Single-transfer 68000 bus initiator. A request is latched on any clk edge,
// then the bus phases advance only on clk7_en ticks. Reads assert the data
// strobes together with AS; writes assert them one tick later so the write
// data is settled first. DTACK is sampled only on clk7_en ticks in WAIT and
// an 8-bit counter aborts the cycle after TIMEOUT unacknowledged ticks.
// Every bus pin is a register, so strobes can only move on ticks or reset.
module m68k_bus_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk7_en,
  m68k_bus_initiator_if.master bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    ASSERT = 3'd2,
    DATA   = 3'd3,
    WAIT   = 3'd4,
    LATCH  = 3'd5,
    END    = 3'd6
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        we_q, we_d, uds_q, uds_d, lds_q, lds_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        errf_q, errf_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [15:0] rdata_q, rdata_d, dout_q, dout_d;
  logic [22:0] addr_q, addr_d;
  logic        as_n_q, as_n_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d;
  logic        rw_q, rw_d;

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.cpu_address  = addr_q;
  assign bus.cpu_data_out = dout_q;
  assign bus._cpu_as      = as_n_q;
  assign bus._cpu_uds     = uds_n_q;
  assign bus._cpu_lds     = lds_n_q;
  assign bus.cpu_r_w      = rw_q;
  assign dbg_state        = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and next values of every datapath/bus register.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uds_d   = uds_q;
    lds_d   = lds_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    errf_d  = errf_q;
    tcnt_d  = tcnt_q;
    rdata_d = rdata_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    as_n_d  = as_n_q;
    uds_n_d = uds_n_q;
    lds_n_d = lds_n_q;
    rw_d    = rw_q;
    case (state_q)
      IDLE: begin
        // Acceptance is not tick-qualified; the address phase waits instead.
        if (bus.req) begin
          we_d   = bus.req_we;
          uds_d  = bus.req_uds;
          lds_d  = bus.req_lds;
          addr_d = bus.req_addr;
          if (bus.req_we) dout_d = bus.req_wdata;
          rw_d    = ~bus.req_we;
          busy_d  = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (clk7_en) begin
          as_n_d = 1'b0;
          if (!we_q) begin
            uds_n_d = ~uds_q;
            lds_n_d = ~lds_q;
          end
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (clk7_en) begin
          if (we_q) begin
            uds_n_d = ~uds_q;
            lds_n_d = ~lds_q;
            state_d = DATA;
          end else begin
            state_d = WAIT;
          end
        end
      end
      DATA: begin
        if (clk7_en) state_d = WAIT;
      end
      WAIT: begin
        if (clk7_en) begin
          if (!bus._cpu_dtack) begin
            state_d = LATCH;
          end else if (tcnt_q == TIMEOUT_CNT) begin
            errf_d  = 1'b1;
            as_n_d  = 1'b1;
            uds_n_d = 1'b1;
            lds_n_d = 1'b1;
            state_d = END;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      LATCH: begin
        if (clk7_en) begin
          if (!we_q) rdata_d = bus.cpu_data_in;
          as_n_d  = 1'b1;
          uds_n_d = 1'b1;
          lds_n_d = 1'b1;
          state_d = END;
        end
      end
      END: begin
        if (clk7_en) begin
          rw_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = errf_q;
          errf_d  = 1'b0;
          tcnt_d  = 8'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and bus pin registers; reset releases every strobe at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      uds_q   <= 1'b0;
      lds_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      errf_q  <= 1'b0;
      tcnt_q  <= 8'd0;
      rdata_q <= 16'd0;
      dout_q  <= 16'd0;
      addr_q  <= 23'd0;
      as_n_q  <= 1'b1;
      uds_n_q <= 1'b1;
      lds_n_q <= 1'b1;
      rw_q    <= 1'b1;
    end else begin
      we_q    <= we_d;
      uds_q   <= uds_d;
      lds_q   <= lds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      errf_q  <= errf_d;
      tcnt_q  <= tcnt_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      as_n_q  <= as_n_d;
      uds_n_q <= uds_n_d;
      lds_n_q <= lds_n_d;
      rw_q    <= rw_d;
    end
  end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Bench for m68k_bus_initiator. A bus environment process generates clk7_en,
// plays the chipset (DTACK after a configurable number of ticks, optional
// DTACK glitches between ticks) and logs strobe edges in tick numbers.
// Expected timing and results come from the bus-phase rules expressed as
// tick arithmetic per transfer.
module tb_m68k_bus_initiator;
  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk7_en = 1'b0;
  logic [2:0] dbg_state;

  m68k_bus_initiator_if bus();

  m68k_bus_initiator #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk7_en   (clk7_en),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_rdata = 16'd0;

  // Environment state.
  int div = 4;
  int div_cnt = 0;
  int tick_no = 0;
  int cfg_dly = 0;
  int fall_t = 0;
  int stab_err = 0;
  int strobe_err = 0;
  bit glitch_en = 1'b0;
  bit en_s;
  logic as_p = 1'b1, uds_p = 1'b1, lds_p = 1'b1;
  int as_fall_q[$], as_rise_q[$], uds_fall_q[$], lds_fall_q[$], done_q[$];
  logic [22:0] mon_addr = '0;
  logic        mon_rw = 1'b1;
  logic [15:0] mon_dout = '0;

  // Bus environment: tick generator, chipset responder and strobe monitor.
  always @(posedge clk) begin
    en_s = clk7_en;
    #1;
    if (en_s) tick_no++;
    if (reset_n && !en_s &&
        ({bus._cpu_as, bus._cpu_uds, bus._cpu_lds} !== {as_p, uds_p, lds_p}))
      strobe_err++;
    if (as_p && !bus._cpu_as) begin
      fall_t = tick_no;
      as_fall_q.push_back(tick_no);
      mon_addr = bus.cpu_address;
      mon_rw   = bus.cpu_r_w;
      mon_dout = bus.cpu_data_out;
    end
    if (!as_p && bus._cpu_as) as_rise_q.push_back(tick_no);
    if (uds_p && !bus._cpu_uds) uds_fall_q.push_back(tick_no);
    if (lds_p && !bus._cpu_lds) lds_fall_q.push_back(tick_no);
    if (!bus._cpu_as &&
        ({bus.cpu_address, bus.cpu_r_w, bus.cpu_data_out} !== {mon_addr, mon_rw, mon_dout}))
      stab_err++;
    if (bus.done === 1'b1) done_q.push_back(tick_no);
    as_p  = bus._cpu_as;
    uds_p = bus._cpu_uds;
    lds_p = bus._cpu_lds;
    div_cnt = (div_cnt + 1) % div;
    clk7_en = (div_cnt == 0);
    if (!bus._cpu_as && reset_n) bus._cpu_dtack = !((tick_no - fall_t) >= cfg_dly - 1);
    else                         bus._cpu_dtack = 1'b1;
    if (glitch_en && !bus._cpu_as && !clk7_en) bus._cpu_dtack = 1'b0;
  end

  task automatic clear_log();
    as_fall_q.delete();
    as_rise_q.delete();
    uds_fall_q.delete();
    lds_fall_q.delete();
    done_q.delete();
    stab_err = 0;
    strobe_err = 0;
  endtask

  // Waits for done with a cycle budget; optionally pulses req at cycle poke_at.
  task automatic wait_done(input int poke_at, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #2;
      cyc++;
      if (poke_at >= 0) bus.req = (cyc == poke_at);
    end while (bus.done !== 1'b1 && cyc < 4000);
  endtask

  // Issues one transfer and checks it against the phase/tick model.
  task automatic do_xfer(input bit we, input logic [22:0] addr, input bit u, input bit l,
                         input logic [15:0] wd, input logic [15:0] din, input int dly,
                         input bit poke, input string nm);
    int cyc, base, w, dur, f;
    bit tmo;
    logic [15:0] exp_rd;
    clear_log();
    cfg_dly = dly;
    bus.cpu_data_in = din;
    bus.req_we = we; bus.req_addr = addr; bus.req_uds = u; bus.req_lds = l;
    bus.req_wdata = wd; bus.req = 1'b1;
    @(posedge clk); #2;
    bus.req = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s accept: busy=%b want 1", nm, bus.busy); end
    // Model: reads reach WAIT 2 ticks after AS falls, writes 3 ticks.
    base = we ? 3 : 2;
    w    = (dly > base) ? dly - base : 0;
    tmo  = (w > TO);
    dur  = tmo ? base + TO : base + w + 1;
    if (!we && !tmo) model_rdata = din;
    exp_q.push_back(model_rdata);
    wait_done(poke ? 3 : 0, cyc);
    exp_rd = exp_q.pop_front();
    total++;
    if (bus.done !== 1'b1) begin
      bad++; $display("FAIL %s done: no done within %0d clks", nm, cyc); return;
    end
    total++;
    if (bus.err !== tmo) begin bad++; $display("FAIL %s err: got %b want %b", nm, bus.err, tmo); end
    total++;
    if (bus.rdata !== exp_rd) begin bad++; $display("FAIL %s rdata: got %h want %h", nm, bus.rdata, exp_rd); end
    total++;
    if (bus.busy !== 1'b0 || bus.cpu_r_w !== 1'b1) begin
      bad++; $display("FAIL %s end_state: busy=%b r_w=%b want 0 1", nm, bus.busy, bus.cpu_r_w);
    end
    total++;
    if ({bus._cpu_as, bus._cpu_uds, bus._cpu_lds} !== 3'b111) begin
      bad++; $display("FAIL %s strobes_released: got %b want 111", nm, {bus._cpu_as, bus._cpu_uds, bus._cpu_lds});
    end
    total++;
    if (as_fall_q.size() != 1 || as_rise_q.size() != 1) begin
      bad++; $display("FAIL %s as_cycles: falls=%0d rises=%0d want 1 1", nm, as_fall_q.size(), as_rise_q.size());
    end else begin
      f = as_fall_q[0];
      total++;
      if (as_rise_q[0] - f != dur) begin
        bad++; $display("FAIL %s as_len: got %0d ticks want %0d", nm, as_rise_q[0] - f, dur);
      end
      total++;
      if (done_q.size() != 1 || done_q[0] - f != dur + 1) begin
        bad++; $display("FAIL %s done_tick: got %0d pulses rel %0d want 1 rel %0d", nm, done_q.size(),
                        (done_q.size() > 0) ? done_q[0] - f : -1, dur + 1);
      end
      total++;
      if (uds_fall_q.size() != int'(u) || (u && uds_fall_q[0] - f != int'(we))) begin
        bad++; $display("FAIL %s uds: got %0d falls rel %0d want %0d rel %0d", nm, uds_fall_q.size(),
                        (uds_fall_q.size() > 0) ? uds_fall_q[0] - f : -1, u, we);
      end
      total++;
      if (lds_fall_q.size() != int'(l) || (l && lds_fall_q[0] - f != int'(we))) begin
        bad++; $display("FAIL %s lds: got %0d falls rel %0d want %0d rel %0d", nm, lds_fall_q.size(),
                        (lds_fall_q.size() > 0) ? lds_fall_q[0] - f : -1, l, we);
      end
    end
    total++;
    if (mon_addr !== addr || mon_rw !== ~we) begin
      bad++; $display("FAIL %s bus_addr: got %h rw=%b want %h rw=%b", nm, mon_addr, mon_rw, addr, ~we);
    end
    if (we) begin
      total++;
      if (mon_dout !== wd) begin bad++; $display("FAIL %s bus_wdata: got %h want %h", nm, mon_dout, wd); end
    end
    total++;
    if (stab_err != 0 || strobe_err != 0) begin
      bad++; $display("FAIL %s stability: addr/data changes=%0d off-tick strobe changes=%0d want 0 0",
                      nm, stab_err, strobe_err);
    end
    if (div == 1) begin
      total++;
      if (cyc != dur + 2) begin bad++; $display("FAIL %s latency: got %0d clks want %0d", nm, cyc, dur + 2); end
    end
    if (poke) begin
      repeat (20) @(posedge clk);
      #2;
      total++;
      if (as_fall_q.size() != 1 || done_q.size() != 1) begin
        bad++; $display("FAIL %s busy_req: got %0d cycles %0d dones want 1 1", nm, as_fall_q.size(), done_q.size());
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      bad++; $display("FAIL reset_flags: busy=%b done=%b err=%b want 0 0 0", bus.busy, bus.done, bus.err);
    end
    total++;
    if (bus.rdata !== 16'd0 || bus.cpu_address !== 23'd0 || bus.cpu_data_out !== 16'd0) begin
      bad++; $display("FAIL reset_data: rdata=%h addr=%h dout=%h want 0 0 0", bus.rdata, bus.cpu_address, bus.cpu_data_out);
    end
    total++;
    if ({bus._cpu_as, bus._cpu_uds, bus._cpu_lds, bus.cpu_r_w} !== 4'b1111) begin
      bad++; $display("FAIL reset_strobes: got %b want 1111", {bus._cpu_as, bus._cpu_uds, bus._cpu_lds, bus.cpu_r_w});
    end
    reset_n = 1'b1;
    model_rdata = 16'd0;
  endtask

  task automatic test_read();
    div = 4; glitch_en = 1'b0;
    do_xfer(1'b0, 23'h7FF000, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 3, 1'b0, "read");
  endtask

  task automatic test_write();
    div = 4; glitch_en = 1'b0;
    do_xfer(1'b1, 23'h000100, 1'b1, 1'b0, 16'h1234, 16'hDEAD, 3, 1'b0, "write");
  endtask

  task automatic test_timeout();
    div = 4; glitch_en = 1'b1;
    do_xfer(1'b0, 23'h012345, 1'b1, 1'b1, 16'h0000, 16'h5555, 255, 1'b0, "timeout");
    glitch_en = 1'b0;
  endtask

  task automatic test_latency();
    div = 1; glitch_en = 1'b0;
    do_xfer(1'b0, 23'h000222, 1'b1, 1'b1, 16'h0000, 16'hC0DE, 0, 1'b0, "lat_read");
    do_xfer(1'b1, 23'h000333, 1'b0, 1'b1, 16'h8001, 16'h0000, 0, 1'b0, "lat_write");
    do_xfer(1'b0, 23'h000444, 1'b0, 1'b0, 16'h0000, 16'h7777, 1, 1'b0, "as_only");
    div = 4;
  endtask

  task automatic test_busy_req();
    div = 4; glitch_en = 1'b0;
    do_xfer(1'b1, 23'h055AA0, 1'b1, 1'b1, 16'hA55A, 16'h0000, 4, 1'b1, "busy_req");
  endtask

  task automatic test_back_to_back();
    int cyc;
    div = 4; glitch_en = 1'b0;
    clear_log();
    cfg_dly = 2;
    bus.cpu_data_in = 16'hA5A5;
    bus.req_we = 1'b0; bus.req_addr = 23'h001000; bus.req_uds = 1'b1; bus.req_lds = 1'b1;
    bus.req = 1'b1;
    @(posedge clk); #2;
    wait_done(-1, cyc);
    total++;
    if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b want 1", bus.done); end
    @(posedge clk); #2;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_restart: busy=%b want 1", bus.busy); end
    bus.req = 1'b0;
    wait_done(-1, cyc);
    model_rdata = 16'hA5A5;
    total++;
    if (bus.done !== 1'b1 || bus.rdata !== model_rdata) begin
      bad++; $display("FAIL b2b_second: done=%b rdata=%h want 1 %h", bus.done, bus.rdata, model_rdata);
    end
    total++;
    if (as_fall_q.size() != 2 || as_rise_q.size() != 2 || done_q.size() != 2) begin
      bad++; $display("FAIL b2b_count: falls=%0d rises=%0d dones=%0d want 2 2 2",
                      as_fall_q.size(), as_rise_q.size(), done_q.size());
    end else begin
      total++;
      if (as_fall_q[1] - as_rise_q[0] < 1) begin
        bad++; $display("FAIL b2b_gap: got %0d ticks want >=1", as_fall_q[1] - as_rise_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    div = 4; glitch_en = 1'b0;
    clear_log();
    cfg_dly = 1000;
    bus.req_we = 1'b0; bus.req_addr = 23'h00ABCD; bus.req_uds = 1'b1; bus.req_lds = 1'b1;
    bus.req = 1'b1;
    @(posedge clk); #2;
    bus.req = 1'b0;
    cyc = 0;
    while ((as_fall_q.size() == 0 || tick_no < as_fall_q[0] + 3) && cyc < 200) begin
      @(posedge clk); #2; cyc++;
    end
    total++;
    if (bus._cpu_as !== 1'b0) begin bad++; $display("FAIL reset_mid_pre: as=%b want 0", bus._cpu_as); end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus._cpu_as !== 1'b1 || bus._cpu_uds !== 1'b1 || bus._cpu_lds !== 1'b1) begin
      bad++; $display("FAIL reset_mid_strobes: got %b want 111", {bus._cpu_as, bus._cpu_uds, bus._cpu_lds});
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy: got %b want 0", bus.busy); end
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (done_q.size() != 0 || bus.done !== 1'b0 || bus.rdata !== 16'd0) begin
      bad++; $display("FAIL reset_mid_nodone: dones=%0d rdata=%h want 0 0000", done_q.size(), bus.rdata);
    end
    reset_n = 1'b1;
    model_rdata = 16'd0;
    do_xfer(1'b0, 23'h00ABCE, 1'b1, 1'b0, 16'h0000, 16'h4321, 3, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [22:0] a;
    logic [15:0] wd, din;
    bit we, u, l;
    for (int i = 0; i < 16; i++) begin
      div = ($urandom_range(0, 1) == 0) ? 1 : 4;
      glitch_en = (div == 4) && ($urandom_range(0, 1) == 1);
      we  = $urandom_range(0, 1);
      u   = $urandom_range(0, 1);
      l   = $urandom_range(0, 1);
      a   = 23'($urandom);
      wd  = 16'($urandom);
      din = 16'($urandom);
      do_xfer(we, a, u, l, wd, din, $urandom_range(0, 8), 1'b0, "random");
    end
    glitch_en = 1'b0;
  endtask

  // Test sequence.
  initial begin
    bus.req = 1'b0; bus.req_addr = '0; bus.req_we = 1'b0; bus.req_uds = 1'b0;
    bus.req_lds = 1'b0; bus.req_wdata = '0; bus.cpu_data_in = '0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_latency();
    test_busy_req();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/m68k_bus_initiator.md
M68K_BUS_INITIATOR -- requirements
Module: m68k_bus_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255: clk7_en ticks spent waiting for DTACK before the cycle is aborted; legal range 1..255.
REQ-002 clk  in  1  28.37516 MHz system clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 clk7_en  in  1  7 MHz clock enable; every bus-phase advance is qualified by it.
REQ-005 req  in  1  transfer request; sampled only while busy=0.
REQ-006 req_addr  in  23  word address [23:1].
REQ-007 req_we  in  1  1=write, 0=read.
REQ-008 req_uds / req_lds  in  1 each  byte enables, active-high.
REQ-009 req_wdata  in  16  write data.
REQ-010 busy  out  1  transfer in progress.
REQ-011 done  out  1  one-clk pulse when a transfer finishes.
REQ-012 err  out  1  qualifies done: 1 = DTACK timeout.
REQ-013 rdata  out  16  read data, held until the next read completes.
REQ-014 cpu_address  out  23  bus address [23:1].
REQ-015 cpu_data_out  out  16  bus write data.
REQ-016 cpu_data_in  in  16  bus read data.
REQ-017 _cpu_as, _cpu_uds, _cpu_lds  out  1 each  active-low strobes.
REQ-018 cpu_r_w  out  1  1=read, 0=write.
REQ-019 _cpu_dtack  in  1  active-low transfer acknowledge from the chipset.

Function
REQ-020 The FSM SHALL have the states IDLE, ADDR, ASSERT, DATA, WAIT, LATCH, END.
REQ-021 IDLE: when req=1 on any clk edge, latch addr, we, uds, lds and wdata; set busy=1; go to ADDR. Requests are not gated by clk7_en.
REQ-022 ADDR: drive cpu_address, cpu_data_out (writes only) and cpu_r_w=~we. On clk7_en, go to ASSERT with _cpu_as=0. For reads, also assert _cpu_uds/_cpu_lds from the latched enables in the same transition.
REQ-023 ASSERT: on clk7_en, a write goes to DATA and asserts _cpu_uds/_cpu_lds from the latched enables; a read goes to WAIT.
REQ-024 DATA: on clk7_en, go to WAIT.
REQ-025 WAIT, on each clk7_en:
- _cpu_dtack=0: go to LATCH.
- _cpu_dtack=1: increment an 8-bit timeout counter.
- Counter already equal to TIMEOUT: go to END with the error flag set, and deassert all strobes in the same transition.
REQ-026 DTACK SHALL be sampled only on clk7_en edges; a DTACK pulse that does not span a clk7_en edge is ignored.
REQ-027 LATCH: on clk7_en:
- Reads capture cpu_data_in into rdata.
- _cpu_as, _cpu_uds and _cpu_lds go high.
- Go to END.
REQ-028 END: on clk7_en:
- cpu_r_w returns to 1.
- busy goes to 0.
- done=1 for exactly one clk cycle.
- err equals the error flag; the error flag is then cleared.
- The timeout counter is cleared.
- Go to IDLE.
REQ-029 A byte enable with req_uds=req_lds=0 SHALL still run a full bus cycle with AS only.
REQ-030 req asserted while busy=1 SHALL be ignored and not queued.
REQ-031 A timed-out read SHALL leave rdata unchanged.
REQ-032 Strobes SHALL only change on clk7_en edges or on reset.
REQ-033 cpu_address, cpu_r_w and cpu_data_out SHALL stay stable from ADDR through LATCH.
REQ-034 With clk7_en continuously 1, a zero-wait-state read (DTACK already low) SHALL take 5 clk edges from IDLE acceptance to done; a write SHALL take 6.

Reset
REQ-035 reset_n=0 SHALL immediately, asynchronously set:
- state=IDLE, busy=0, done=0, err=0;
- rdata=0, cpu_address=0, cpu_data_out=0;
- _cpu_as=_cpu_uds=_cpu_lds=1, cpu_r_w=1;
- timeout counter=0.
REQ-036 Reset asserted mid-transfer SHALL release all strobes within the same clk cycle, with no done pulse.
REQ-037 After reset_n deasserts, the first transfer SHALL be accepted on the first clk edge with req=1.

Verification
REQ-038 Read with clk7_en every 4th clk: addr=0x7FF000, uds=lds=1, DTACK low on the 2nd WAIT tick, data_in=0xBEEF. Required: done=1, err=0, rdata=0xBEEF; AS low for exactly 4 clk7_en periods.
REQ-039 Write: addr=0x000100, wdata=0x1234, uds=1, lds=0. Required: cpu_r_w=0 from ADDR; _cpu_uds falls one clk7_en after _cpu_as; _cpu_lds stays 1; cpu_data_out=0x1234 throughout.
REQ-040 Timeout with TIMEOUT=3 and DTACK held high. Required: done with err=1 after 4 WAIT ticks, strobes released, rdata unchanged.
REQ-041 req pulsed during busy. Required: no second bus cycle, exactly one done.
REQ-042 reset_n dropped while in WAIT. Required: _cpu_as=1 and busy=0 asynchronously; the next req completes normally.
REQ-043 Back-to-back: req held high across done. Required: a second transfer starts on the clk after END, with _cpu_as high for at least one clk7_en period between the two cycles.
